// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register completer.
package apb_slave_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } apb_state_e;

   localparam logic [9:0]  OFS_ID           = 10'd0;
   localparam logic [9:0]  OFS_CTRL         = 10'd1;
   localparam logic [9:0]  OFS_WCOUNT       = 10'd2;
   localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA9B0_0001;

   // Registers that reject writes with an error response.
   function automatic logic is_read_only(input logic [9:0] ofs);
      return (ofs == OFS_ID) || (ofs == OFS_WCOUNT);
   endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between an initiator (bridge) and the register completer.
interface apb_reg_slave_if;

   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_wait_timer.sv
// Loadable 4-bit down-counter; done_o marks the last wait cycle (count of one).
module apb_wait_timer (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       en_i,
   output logic       done_o
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with ID/CTRL/WCOUNT/SCRATCH registers and programmable wait states.
module apb_reg_slave
   import apb_slave_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   apb_reg_slave_if.slave        bus,
   output logic [31:0]           ctrl_out
);

   localparam int unsigned IdxW = $clog2(NUM_REGS);

   apb_state_e  state_q;
   logic [11:0] addr_q;
   logic        wr_q;
   logic [31:0] wdata_q;
   logic [31:0] prdata_q;
   logic        pready_q;
   logic        pslverr_q;
   logic [31:0] ctrl_q, ctrl_d;
   logic [31:0] wcount_q, wcount_d;
   logic [31:0] reg_rd [NUM_REGS];

   logic        setup;
   logic [11:0] dec_addr;
   logic        dec_wr;
   logic [9:0]  dec_ofs;
   logic        dec_err;
   logic [31:0] dec_rdata;
   logic        commit;
   logic [9:0]  cmt_ofs;
   logic        tmr_load;
   logic        tmr_done;
   logic        unused_paddr;

   assign unused_paddr = ^bus.paddr[31:12];
   assign setup        = bus.psel && !bus.penable;

   // From IDLE the response is decoded straight off the bus so W=0 needs no extra cycle.
   always_comb begin
      dec_addr  = (state_q == StIdle) ? bus.paddr[11:0] : addr_q;
      dec_wr    = (state_q == StIdle) ? bus.pwrite : wr_q;
      dec_ofs   = dec_addr[11:2];
      dec_err   = (dec_addr[1:0] != 2'b00) || (32'(dec_ofs) >= NUM_REGS) ||
                  (dec_wr && is_read_only(dec_ofs));
      dec_rdata = (dec_err || dec_wr) ? 32'h0 : reg_rd[dec_ofs[IdxW-1:0]];
   end

   // pslverr_q is the captured transfer's error flag while in RESP.
   assign commit  = (state_q == StResp) && wr_q && !pslverr_q;
   assign cmt_ofs = addr_q[11:2];

   always_comb begin
      ctrl_d   = ctrl_q;
      wcount_d = wcount_q;
      if (commit) begin
         wcount_d = wcount_q + 32'd1;
         if (cmt_ofs == OFS_CTRL) begin
            ctrl_d = wdata_q;
         end
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         ctrl_q   <= 32'h0;
         wcount_q <= 32'h0;
      end else begin
         ctrl_q   <= ctrl_d;
         wcount_q <= wcount_d;
      end
   end

   assign reg_rd[0] = ID_VALUE;
   assign reg_rd[1] = ctrl_q;
   assign reg_rd[2] = wcount_q;

   for (genvar g = 3; g < NUM_REGS; g++) begin : g_scratch
      logic [31:0] scr_q;
      always_ff @(posedge hclk or negedge hresetn) begin
         if (!hresetn) begin
            scr_q <= 32'h0;
         end else if (commit && (cmt_ofs == 10'(g))) begin
            scr_q <= wdata_q;
         end
      end
      assign reg_rd[g] = scr_q;
   end

   assign tmr_load = (state_q == StIdle) && setup;

   apb_wait_timer u_timer (
      .clk_i      (hclk),
      .rst_ni     (hresetn),
      .load_i     (tmr_load),
      .load_val_i (4'(WAIT_STATES)),
      .en_i       (state_q == StWait),
      .done_o     (tmr_done)
   );

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q   <= StIdle;
         addr_q    <= 12'h0;
         wr_q      <= 1'b0;
         wdata_q   <= 32'h0;
         prdata_q  <= 32'h0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         prdata_q  <= 32'h0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (setup) begin
                  addr_q  <= bus.paddr[11:0];
                  wr_q    <= bus.pwrite;
                  wdata_q <= bus.pwdata;
                  if (WAIT_STATES == 0) begin
                     state_q   <= StResp;
                     prdata_q  <= dec_rdata;
                     pready_q  <= 1'b1;
                     pslverr_q <= dec_err;
                  end else begin
                     state_q <= StWait;
                  end
               end
            end
            StWait: begin
               if (!bus.psel || !bus.penable) begin
                  state_q <= StIdle;
               end else if (tmr_done) begin
                  state_q   <= StResp;
                  prdata_q  <= dec_rdata;
                  pready_q  <= 1'b1;
                  pslverr_q <= dec_err;
               end
            end
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.prdata  = prdata_q;
   assign bus.pready  = pready_q;
   assign bus.pslverr = pslverr_q;
   assign ctrl_out    = ctrl_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: one instance with no wait states, one with three.
module tb_apb_reg_slave;
   import apb_slave_pkg::*;

   localparam int unsigned NREGS = 8;
   localparam bit          W0    = 1'b0;
   localparam bit          W3    = 1'b1;

   logic hclk;
   logic rst_n [2];

   logic        psel_v    [2];
   logic        penable_v [2];
   logic        pwrite_v  [2];
   logic [31:0] paddr_v   [2];
   logic [31:0] pwdata_v  [2];

   logic        act_rdy  [2];
   logic        act_err  [2];
   logic [31:0] act_prd  [2];
   logic [31:0] act_ctrl [2];

   apb_reg_slave_if b0 ();
   apb_reg_slave_if b3 ();

   assign b0.psel    = psel_v[0];
   assign b0.penable = penable_v[0];
   assign b0.pwrite  = pwrite_v[0];
   assign b0.paddr   = paddr_v[0];
   assign b0.pwdata  = pwdata_v[0];
   assign b3.psel    = psel_v[1];
   assign b3.penable = penable_v[1];
   assign b3.pwrite  = pwrite_v[1];
   assign b3.paddr   = paddr_v[1];
   assign b3.pwdata  = pwdata_v[1];

   assign act_rdy[0] = b0.pready;
   assign act_err[0] = b0.pslverr;
   assign act_prd[0] = b0.prdata;
   assign act_rdy[1] = b3.pready;
   assign act_err[1] = b3.pslverr;
   assign act_prd[1] = b3.prdata;

   apb_reg_slave #(.NUM_REGS(NREGS), .WAIT_STATES(0)) u_w0 (
      .hclk     (hclk),
      .hresetn  (rst_n[0]),
      .bus      (b0),
      .ctrl_out (act_ctrl[0])
   );

   apb_reg_slave #(.NUM_REGS(NREGS), .WAIT_STATES(3)) u_w3 (
      .hclk     (hclk),
      .hresetn  (rst_n[1]),
      .bus      (b3),
      .ctrl_out (act_ctrl[1])
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // Behavioural model: register contents and expected outputs per bus.
   logic [31:0] m_reg     [2][NREGS];
   logic [31:0] m_wcount  [2];
   logic        pend_wr   [2];
   logic [2:0]  pend_ofs  [2];
   logic [31:0] pend_data [2];
   logic        exp_pready  [2];
   logic        exp_pslverr [2];
   logic [31:0] exp_prdata  [2];
   logic [31:0] exp_ctrl    [2];
   logic        chk_prd     [2];
   logic        chk_en;

   int total;
   int bad;

   task automatic cmp(input string name, input bit b, input logic [31:0] act,
                      input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s bus%0d: got %h want %h (t=%0t)", name, b, act, want, $time);
      end
   endtask

   function automatic bit m_err(input logic [11:0] addr, input bit wr);
      int unsigned ofs;
      ofs = {22'h0, addr[11:2]};
      return (addr[1:0] != 2'b00) || (ofs >= NREGS) || (wr && (ofs == 0 || ofs == 2));
   endfunction

   function automatic logic [31:0] m_read(input bit b, input logic [2:0] ofs);
      if (ofs == 3'd0) return 32'hA9B0_0001;
      if (ofs == 3'd2) return m_wcount[b];
      return m_reg[b][ofs];
   endfunction

   task automatic model_reset(input bit b);
      for (int k = 0; k < NREGS; k++) m_reg[b][k] = 32'h0;
      m_wcount[b]    = 32'h0;
      pend_wr[b]     = 1'b0;
      pend_ofs[b]    = 3'd0;
      pend_data[b]   = 32'h0;
      exp_pready[b]  = 1'b0;
      exp_pslverr[b] = 1'b0;
      exp_prdata[b]  = 32'h0;
      exp_ctrl[b]    = 32'h0;
      chk_prd[b]     = 1'b1;
   endtask

   task automatic check_bus(input bit b);
      cmp("pready", b, {31'h0, act_rdy[b]}, {31'h0, exp_pready[b]});
      cmp("pslverr", b, {31'h0, act_err[b]}, {31'h0, exp_pslverr[b]});
      if (chk_prd[b]) cmp("prdata", b, act_prd[b], exp_prdata[b]);
      cmp("ctrl_out", b, act_ctrl[b], exp_ctrl[b]);
   endtask

   always @(negedge hclk) begin
      if (chk_en) begin
         check_bus(W0);
         check_bus(W3);
      end
   end

   // Advance one cycle; a write completed in the previous cycle is now visible.
   task automatic step(input bit b);
      @(posedge hclk);
      #1;
      if (pend_wr[b]) begin
         m_reg[b][pend_ofs[b]] = pend_data[b];
         m_wcount[b] = m_wcount[b] + 32'd1;
         pend_wr[b] = 1'b0;
      end
      exp_ctrl[b]    = m_reg[b][1];
      exp_pready[b]  = 1'b0;
      exp_pslverr[b] = 1'b0;
      exp_prdata[b]  = 32'h0;
      chk_prd[b]     = 1'b1;
   endtask

   task automatic idle(input bit b, input int n);
      repeat (n) begin
         step(b);
         psel_v[b]    = 1'b0;
         penable_v[b] = 1'b0;
      end
   endtask

   // cut_kind: 1 = drop psel in access cycle cut_at, 2 = assert reset there.
   task automatic xfer(input bit b, input bit wr, input logic [11:0] addr,
                       input logic [31:0] data, input int cut_at, input int cut_kind,
                       output logic [31:0] got_rd, output logic got_err, output int lat);
      int          w;
      bit          e;
      logic [31:0] rd;
      w = b ? 3 : 0;
      step(b);
      e  = m_err(addr, wr);
      rd = (e || wr) ? 32'h0 : m_read(b, addr[4:2]);
      psel_v[b]    = 1'b1;
      penable_v[b] = 1'b0;
      pwrite_v[b]  = wr;
      paddr_v[b]   = {20'h0, addr};
      pwdata_v[b]  = data;
      got_rd  = 32'h0;
      got_err = 1'b0;
      lat     = 0;
      for (int k = 1; k <= w + 1; k++) begin
         step(b);
         penable_v[b] = 1'b1;
         if (k == cut_at) begin
            psel_v[b]    = 1'b0;
            penable_v[b] = 1'b0;
            if (cut_kind == 2) begin
               rst_n[b] = 1'b0;
               model_reset(b);
               #1;
               cmp("rst_ctrl_out", b, act_ctrl[b], 32'h0);
               cmp("rst_pready", b, {31'h0, act_rdy[b]}, 32'h0);
            end
            step(b);
            rst_n[b] = 1'b1;
            @(negedge hclk);
            return;
         end
         if (k == w + 1) begin
            exp_pready[b]  = 1'b1;
            exp_pslverr[b] = e;
            exp_prdata[b]  = rd;
            chk_prd[b]     = !wr;
         end
         @(negedge hclk);
         if (act_rdy[b] && lat == 0) lat = k;
         if (k == w + 1) begin
            got_rd  = act_prd[b];
            got_err = act_err[b];
         end
      end
      if (wr && !e) begin
         pend_wr[b]   = 1'b1;
         pend_ofs[b]  = addr[4:2];
         pend_data[b] = data;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish before 100us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      total  = 0;
      bad    = 0;
      chk_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         rst_n[k]     = 1'b0;
         psel_v[k]    = 1'b0;
         penable_v[k] = 1'b0;
         pwrite_v[k]  = 1'b0;
         paddr_v[k]   = 32'h0;
         pwdata_v[k]  = 32'h0;
      end
      model_reset(W0);
      model_reset(W3);
      #2 chk_en = 1'b1;
      repeat (2) @(posedge hclk);
      #1;
      cmp("reset_prdata", W0, act_prd[0], 32'h0);
      cmp("reset_pready", W3, {31'h0, act_rdy[1]}, 32'h0);
      cmp("reset_ctrl_out", W3, act_ctrl[1], 32'h0);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      idle(W0, 1);

      // ID read, then write CTRL with read-after-write back to back
      xfer(W0, 1'b0, 12'h000, 32'h0, 0, 0, rd, er, lat);
      cmp("id_read", W0, rd, 32'hA9B0_0001);
      cmp("id_err", W0, {31'h0, er}, 32'h0);
      cmp("id_latency", W0, lat, 32'd1);
      xfer(W0, 1'b1, 12'h004, 32'h1234_5678, 0, 0, rd, er, lat);
      cmp("wr_ctrl_err", W0, {31'h0, er}, 32'h0);
      xfer(W0, 1'b0, 12'h004, 32'h0, 0, 0, rd, er, lat);
      cmp("ctrl_out_after_wr", W0, act_ctrl[0], 32'h1234_5678);
      cmp("ctrl_read", W0, rd, 32'h1234_5678);
      xfer(W0, 1'b0, 12'h008, 32'h0, 0, 0, rd, er, lat);
      cmp("wcount_read", W0, rd, 32'd1);

      // Error responses leave state untouched
      xfer(W0, 1'b1, 12'h000, 32'hDEAD_BEEF, 0, 0, rd, er, lat);
      cmp("err_wr_id", W0, {31'h0, er}, 32'h1);
      xfer(W0, 1'b1, 12'h008, 32'h0000_0055, 0, 0, rd, er, lat);
      cmp("err_wr_wcount", W0, {31'h0, er}, 32'h1);
      xfer(W0, 1'b1, 12'h002, 32'h0000_0077, 0, 0, rd, er, lat);
      cmp("err_wr_misaligned", W0, {31'h0, er}, 32'h1);
      xfer(W0, 1'b0, 12'h020, 32'h0, 0, 0, rd, er, lat);
      cmp("err_rd_oor", W0, {31'h0, er}, 32'h1);
      cmp("err_rd_oor_data", W0, rd, 32'h0);
      xfer(W0, 1'b0, 12'h006, 32'h0, 0, 0, rd, er, lat);
      cmp("err_rd_misaligned", W0, {31'h0, er}, 32'h1);
      cmp("err_rd_misaligned_data", W0, rd, 32'h0);
      xfer(W0, 1'b0, 12'h004, 32'h0, 0, 0, rd, er, lat);
      cmp("ctrl_kept", W0, rd, 32'h1234_5678);
      xfer(W0, 1'b0, 12'h008, 32'h0, 0, 0, rd, er, lat);
      cmp("wcount_kept", W0, rd, 32'd1);
      idle(W0, 1);

      // WCOUNT wrap
      force u_w0.wcount_q = 32'hFFFF_FFFF;
      m_wcount[0] = 32'hFFFF_FFFF;
      @(negedge hclk);
      release u_w0.wcount_q;
      xfer(W0, 1'b1, 12'h00C, 32'h0000_00C3, 0, 0, rd, er, lat);
      xfer(W0, 1'b0, 12'h008, 32'h0, 0, 0, rd, er, lat);
      cmp("wcount_wrap", W0, rd, 32'h0);
      xfer(W0, 1'b0, 12'h00C, 32'h0, 0, 0, rd, er, lat);
      cmp("scratch3_read", W0, rd, 32'h0000_00C3);
      idle(W0, 1);

      // Three wait states
      xfer(W3, 1'b1, 12'h014, 32'hCAFE_0005, 0, 0, rd, er, lat);
      cmp("w3_wr_latency", W3, lat, 32'd4);
      cmp("w3_wr_err", W3, {31'h0, er}, 32'h0);
      xfer(W3, 1'b0, 12'h014, 32'h0, 0, 0, rd, er, lat);
      cmp("w3_rd_latency", W3, lat, 32'd4);
      cmp("w3_scratch5", W3, rd, 32'hCAFE_0005);
      xfer(W3, 1'b1, 12'h004, 32'hA5A5_0003, 0, 0, rd, er, lat);
      cmp("w3_ctrl_before_commit", W3, act_ctrl[1], 32'h0);
      idle(W3, 1);
      cmp("w3_ctrl_after_commit", W3, act_ctrl[1], 32'hA5A5_0003);

      // Abort in A2: no commit, back in IDLE
      xfer(W3, 1'b1, 12'h004, 32'h1111_1111, 2, 1, rd, er, lat);
      cmp("abort_idle", W3, 32'(u_w3.state_q), 32'(StIdle));
      xfer(W3, 1'b0, 12'h004, 32'h0, 0, 0, rd, er, lat);
      cmp("abort_no_commit", W3, rd, 32'hA5A5_0003);
      xfer(W3, 1'b0, 12'h008, 32'h0, 0, 0, rd, er, lat);
      cmp("abort_wcount", W3, rd, 32'd2);

      // Reset during WAIT
      xfer(W3, 1'b1, 12'h00C, 32'h2222_2222, 2, 2, rd, er, lat);
      xfer(W3, 1'b0, 12'h004, 32'h0, 0, 0, rd, er, lat);
      cmp("post_rst_ctrl", W3, rd, 32'h0);
      cmp("post_rst_latency", W3, lat, 32'd4);
      xfer(W3, 1'b0, 12'h014, 32'h0, 0, 0, rd, er, lat);
      cmp("post_rst_scratch5", W3, rd, 32'h0);
      xfer(W3, 1'b0, 12'h00C, 32'h0, 0, 0, rd, er, lat);
      cmp("post_rst_scratch3", W3, rd, 32'h0);
      xfer(W3, 1'b0, 12'h008, 32'h0, 0, 0, rd, er, lat);
      cmp("post_rst_wcount", W3, rd, 32'h0);
      idle(W3, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
